// File: rtl/mem_responder.sv
// mem_responder: instruction/data RAM pair with a boot-load FSM.
// The core is held in reset while instruction RAM is filled over a
// valid/ready stream; afterwards fetch and load/store traffic are served.
module mem_responder #(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boot_valid,
  input  logic [31:0]      boot_data,
  input  logic             boot_last,
  output logic             boot_ready,
  output logic             cpu_rst,
  input  logic [31:0]      addr,
  output logic [31:0]      instr,
  input  logic [31:0]      wr_addr_s,
  input  logic [31:0]      data2_s,
  input  logic             lw_en_s,
  input  logic             sw_en_s,
  output logic [31:0]      data_mem,
  output logic             err,
  output logic [CNT_W-1:0] ld_cnt,
  output logic [CNT_W-1:0] st_cnt
);

  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t           state_q;
  logic [IA:0]      ptr_q;        // one extra bit flags "instruction RAM full"
  logic             err_q;
  logic             cpu_rst_q;
  logic             boot_ready_q;
  logic [CNT_W-1:0] ld_cnt_q;
  logic [CNT_W-1:0] st_cnt_q;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  logic          run;
  logic          fetch_ok;
  logic          d_legal;
  logic [DA-1:0] didx;
  logic          do_load;
  logic          do_store;
  logic          boot_acc;
  logic          imem_we;
  logic          err_d;

  // Decode fetch/data legality and the boot handshake.
  always_comb begin
    run      = (state_q == S_RUN);
    fetch_ok = run && (addr[1:0] == 2'b00) && (addr[31:IA+2] == '0);
    d_legal  = (wr_addr_s[1:0] == 2'b00) && (wr_addr_s[31:DA+2] == '0);
    didx     = wr_addr_s[DA+1:2];
    do_load  = run && lw_en_s && d_legal;
    do_store = run && sw_en_s && d_legal;
    boot_acc = (state_q == S_LOAD) && boot_valid && boot_ready_q;
    imem_we  = boot_acc && !ptr_q[IA];
    // Illegal access, simultaneous load+store, or boot overflow all latch err.
    err_d    = err_q
             | (run && lw_en_s && !d_legal)
             | (run && sw_en_s && !d_legal)
             | (run && lw_en_s && sw_en_s)
             | (boot_acc && ptr_q[IA]);
  end

  // Combinational read ports: fetch and load data are visible the same cycle.
  always_comb begin
    instr    = fetch_ok ? imem[addr[IA+1:2]] : NOP_INSTR;
    data_mem = do_load ? dmem[didx] : 32'h0;
  end

  // RAM write ports; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (imem_we) imem[ptr_q[IA-1:0]] <= boot_data;
    if (do_store) dmem[didx] <= data2_s;
  end

  // Boot FSM with registered handshake/reset outputs, error and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LOAD;
      ptr_q        <= '0;
      err_q        <= 1'b0;
      cpu_rst_q    <= 1'b1;
      boot_ready_q <= 1'b1;
      ld_cnt_q     <= '0;
      st_cnt_q     <= '0;
    end else begin
      err_q <= err_d;
      case (state_q)
        S_LOAD: begin
          if (boot_acc) begin
            if (!ptr_q[IA]) ptr_q <= ptr_q + 1'b1;
            if (boot_last) begin
              state_q      <= S_RUN;
              cpu_rst_q    <= 1'b0;
              boot_ready_q <= 1'b0;
            end
          end
        end
        default: begin
          if (do_load && (ld_cnt_q != '1)) ld_cnt_q <= ld_cnt_q + 1'b1;
          if (do_store && (st_cnt_q != '1)) st_cnt_q <= st_cnt_q + 1'b1;
        end
      endcase
    end
  end

  assign boot_ready = boot_ready_q;
  assign cpu_rst    = cpu_rst_q;
  assign err        = err_q;
  assign ld_cnt     = ld_cnt_q;
  assign st_cnt     = st_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (CNT_W=4 so saturation is reachable).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_valid;
  logic [31:0] boot_data;
  logic        boot_last;
  logic        boot_ready;
  logic        cpu_rst;
  logic [31:0] addr;
  logic [31:0] instr;
  logic [31:0] wr_addr_s;
  logic [31:0] data2_s;
  logic        lw_en_s;
  logic        sw_en_s;
  logic [31:0] data_mem;
  logic        err;
  logic [3:0]  ld_cnt;
  logic [3:0]  st_cnt;

  int checks   = 0;
  int failures = 0;

  mem_responder #(
    .IMEM_WORDS(256), .DMEM_WORDS(256), .CNT_W(4), .NOP_INSTR(32'h00000013)
  ) dut (
    .clk(clk), .rst(rst),
    .boot_valid(boot_valid), .boot_data(boot_data), .boot_last(boot_last),
    .boot_ready(boot_ready), .cpu_rst(cpu_rst),
    .addr(addr), .instr(instr),
    .wr_addr_s(wr_addr_s), .data2_s(data2_s), .lw_en_s(lw_en_s), .sw_en_s(sw_en_s),
    .data_mem(data_mem), .err(err), .ld_cnt(ld_cnt), .st_cnt(st_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic boot_word(input logic [31:0] d, input logic last);
    boot_valid = 1'b1; boot_data = d; boot_last = last;
    tick();
    boot_valid = 1'b0; boot_last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic mem_op(input logic lw, input logic sw, input logic [31:0] a, input logic [31:0] d);
    lw_en_s = lw; sw_en_s = sw; wr_addr_s = a; data2_s = d;
  endtask

  initial begin
    rst = 1'b1; boot_valid = 1'b0; boot_data = '0; boot_last = 1'b0;
    addr = '0; wr_addr_s = '0; data2_s = '0; lw_en_s = 1'b0; sw_en_s = 1'b0;

    // Reset state
    do_reset();
    check("rst_cpu_rst", {31'b0, cpu_rst}, 32'h1);
    check("rst_boot_ready", {31'b0, boot_ready}, 32'h1);
    check("rst_instr_nop", instr, 32'h00000013);
    check("rst_data_mem", data_mem, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_ld_cnt", {28'b0, ld_cnt}, 32'h0);

    // Load/store traffic during LOAD is ignored
    mem_op(1'b1, 1'b0, 32'h12, 32'h0);
    tick();
    mem_op(1'b0, 1'b0, 32'h0, 32'h0);
    check("load_phase_err", {31'b0, err}, 32'h0);
    check("load_phase_ld_cnt", {28'b0, ld_cnt}, 32'h0);

    // Boot 4 words back to back
    boot_word(32'h00100093, 1'b0);
    boot_word(32'h00200113, 1'b0);
    boot_word(32'h002081B3, 1'b0);
    check("boot3_cpu_rst_high", {31'b0, cpu_rst}, 32'h1);
    boot_word(32'h00000013, 1'b1);
    check("boot4_cpu_rst_low", {31'b0, cpu_rst}, 32'h0);
    check("boot4_ready_low", {31'b0, boot_ready}, 32'h0);
    addr = 32'h8;   #1; check("fetch_0x8", instr, 32'h002081B3);
    addr = 32'h4;   #1; check("fetch_0x4", instr, 32'h00200113);
    addr = 32'hA;   #1; check("fetch_misaligned", instr, 32'h00000013);
    addr = 32'h400; #1; check("fetch_out_of_range", instr, 32'h00000013);

    // Store then load same word
    mem_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    tick();
    mem_op(1'b1, 1'b0, 32'h10, 32'h0);
    #1; check("load_after_store", data_mem, 32'hDEADBEEF);
    tick();
    mem_op(1'b0, 1'b0, 32'h0, 32'h0);
    #1; check("idle_data_mem", data_mem, 32'h0);
    check("ld_cnt_1", {28'b0, ld_cnt}, 32'h1);
    check("st_cnt_1", {28'b0, st_cnt}, 32'h1);
    check("err_clean", {31'b0, err}, 32'h0);

    // Known value at word 0 so the aliased out-of-range store can be detected
    mem_op(1'b0, 1'b1, 32'h0, 32'h11111111);
    tick();

    // Misaligned load
    mem_op(1'b1, 1'b0, 32'h12, 32'h0);
    #1; check("misaligned_data_mem", data_mem, 32'h0);
    tick();
    check("misaligned_err", {31'b0, err}, 32'h1);
    check("misaligned_ld_cnt", {28'b0, ld_cnt}, 32'h1);

    // Out-of-range store
    mem_op(1'b0, 1'b1, 32'h400, 32'h55555555);
    tick();
    check("oor_store_st_cnt", {28'b0, st_cnt}, 32'h2);
    check("oor_store_err", {31'b0, err}, 32'h1);
    mem_op(1'b1, 1'b0, 32'h0, 32'h0);
    #1; check("oor_store_no_write", data_mem, 32'h11111111);
    tick();

    // Simultaneous load and store
    mem_op(1'b0, 1'b1, 32'h20, 32'h1);
    tick();
    mem_op(1'b1, 1'b1, 32'h20, 32'h2);
    #1; check("ldst_old_value", data_mem, 32'h1);
    tick();
    mem_op(1'b1, 1'b0, 32'h20, 32'h0);
    #1; check("ldst_new_value", data_mem, 32'h2);
    tick();
    mem_op(1'b0, 1'b0, 32'h0, 32'h0);
    check("ldst_ld_cnt", {28'b0, ld_cnt}, 32'h4);
    check("ldst_st_cnt", {28'b0, st_cnt}, 32'h4);
    check("ldst_err", {31'b0, err}, 32'h1);

    // Counter saturation: 20 more loads
    mem_op(1'b1, 1'b0, 32'h20, 32'h0);
    idle(20);
    mem_op(1'b0, 1'b0, 32'h0, 32'h0);
    check("ld_cnt_saturated", {28'b0, ld_cnt}, 32'hF);

    // Reset mid-run
    do_reset();
    check("rerun_cpu_rst", {31'b0, cpu_rst}, 32'h1);
    check("rerun_ld_cnt", {28'b0, ld_cnt}, 32'h0);
    check("rerun_st_cnt", {28'b0, st_cnt}, 32'h0);
    check("rerun_err", {31'b0, err}, 32'h0);
    addr = 32'h8; #1; check("rerun_instr_nop", instr, 32'h00000013);

    // Reset mid-boot after two words, then boot with idle gaps
    boot_word(32'hAAAA0000, 1'b0);
    idle(3);
    boot_word(32'hAAAA0001, 1'b0);
    do_reset();
    check("midboot_cpu_rst", {31'b0, cpu_rst}, 32'h1);
    check("midboot_ready", {31'b0, boot_ready}, 32'h1);
    boot_word(32'hBBBB0000, 1'b0);
    idle(3);
    boot_word(32'hBBBB0001, 1'b0);
    idle(3);
    boot_word(32'hBBBB0002, 1'b0);
    idle(3);
    check("gap_still_loading", {31'b0, cpu_rst}, 32'h1);
    boot_word(32'hBBBB0003, 1'b1);
    check("gap_cpu_rst_low", {31'b0, cpu_rst}, 32'h0);
    check("gap_err", {31'b0, err}, 32'h0);
    addr = 32'h0; #1; check("gap_fetch_0", instr, 32'hBBBB0000);
    addr = 32'hC; #1; check("gap_fetch_C", instr, 32'hBBBB0003);

    // Boot overflow: 256 words fill RAM, the 257th is dropped
    do_reset();
    for (int i = 0; i < 256; i++) boot_word(32'(i), 1'b0);
    check("full_err_clear", {31'b0, err}, 32'h0);
    check("full_ready", {31'b0, boot_ready}, 32'h1);
    boot_word(32'hABCD0000, 1'b1);
    check("overflow_err", {31'b0, err}, 32'h1);
    check("overflow_cpu_rst", {31'b0, cpu_rst}, 32'h0);
    addr = 32'h3FC; #1; check("overflow_last_word", instr, 32'h000000FF);
    addr = 32'h0;   #1; check("overflow_first_word", instr, 32'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
